// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared types and constants for the argmax engine
// Contents:
//   state_t    : engine state (ST_FIRST, ST_ACCUM, ST_DONE)
//   TIE_FIRST  : tie policy, keep earliest index on equal values
//   TIE_LAST   : tie policy, take latest index on equal values
package argmax_pkg;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam bit TIE_FIRST = 1'b0;
    localparam bit TIE_LAST  = 1'b1;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - combinational unsigned comparator with tie policy
// Ports:
//   a        in  WIDTH  incumbent value
//   b        in  WIDTH  challenger value
//   tie_last in  1      1: equal values favour b, 0: equal values keep a
//   take_b   out 1      challenger wins
module argmax_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             tie_last,
    output logic             take_b
);

    assign take_b = tie_last ? (b >= a) : (b > a);

endmodule

// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming argmax over frames of up to COUNT values
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     element handshake
//   in_value, in_last     element value (unsigned), end-of-frame marker
//   out_valid/out_ready   result handshake, result held until accepted
//   out_value             maximum of the frame
//   out_label             index of the maximum within the frame
//   out_count             number of elements in the frame
module argmax_stream #(
    parameter int WIDTH    = 8,
    parameter int COUNT    = 26,
    parameter int LBL_W    = (COUNT > 1) ? $clog2(COUNT) : 1,
    parameter int CNT_W    = $clog2(COUNT + 1),
    parameter bit TIE_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [LBL_W-1:0] out_label,
    output logic [CNT_W-1:0] out_count
);
    import argmax_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic [WIDTH-1:0] best_val;
    logic [LBL_W-1:0] best_lbl;
    logic [WIDTH-1:0] nxt_val;
    logic [LBL_W-1:0] nxt_lbl;
    logic             take_b;
    logic             accept;
    logic             frame_full;

    // Ready depends only on state; it is held low while reset is applied so
    // nothing is offered as accepted on the reset edge.
    assign in_ready   = (state != ST_DONE) && !rst;
    assign accept     = in_valid && in_ready;
    assign idx_inc    = idx + CNT_W'(1);
    // The element being accepted now is the COUNT-th one.
    assign frame_full = (idx == CNT_W'(COUNT - 1));

    argmax_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a        (best_val),
        .b        (in_value),
        .tie_last (TIE_LAST),
        .take_b   (take_b)
    );

    always_comb begin
        nxt_val = best_val;
        nxt_lbl = best_lbl;
        if (take_b) begin
            nxt_val = in_value;
            nxt_lbl = LBL_W'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FIRST;
            idx       <= '0;
            best_val  <= '0;
            best_lbl  <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_label <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_FIRST: begin
                    if (accept) begin
                        best_val <= in_value;
                        best_lbl <= '0;
                        idx      <= CNT_W'(1);
                        if (in_last || (COUNT == 1)) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_value <= in_value;
                            out_label <= '0;
                            out_count <= CNT_W'(1);
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        best_val <= nxt_val;
                        best_lbl <= nxt_lbl;
                        idx      <= idx_inc;
                        if (in_last || frame_full) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_value <= nxt_val;
                            out_label <= nxt_lbl;
                            out_count <= idx_inc;
                        end
                    end
                end
                ST_DONE: begin
                    // Result registers stay untouched until the next frame ends.
                    if (out_ready) begin
                        state     <= ST_FIRST;
                        out_valid <= 1'b0;
                        idx       <= '0;
                    end
                end
                default: begin
                    state <= ST_FIRST;
                end
            endcase
        end
    end

endmodule
